// File: rtl/rop3_stream.sv
// rop3_stream: two-stage multi-lane ROP3 engine with valid/ready handshake.
// Optional transparency key compare enabled by `define ROP3_TRANSP_EN.
module rop3_stream #(
  parameter int N     = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_mode,
  input  logic [LANES*N-1:0] in_p,
  input  logic [LANES*N-1:0] in_s,
  input  logic [LANES*N-1:0] in_d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic [7:0]         out_mode,
  input  logic               cnt_clr,
`ifdef ROP3_TRANSP_EN
  input  logic [N-1:0]       key,
`endif
  output logic [CNT_W-1:0]   beat_cnt
);

  logic               r_v1;
  logic               r_v2;
  logic [7:0]         r_mode1;
  logic [LANES*N-1:0] r_p;
  logic [LANES*N-1:0] r_s;
  logic [LANES*N-1:0] r_d;
  logic [LANES*N-1:0] r_res;
  logic [7:0]         r_mode2;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_adv1;
  logic               w_adv2;
  logic               w_oxfer;
  logic [LANES*N-1:0] w_rop;
  logic [LANES*N-1:0] w_res;

  assign w_adv2  = !r_v2 || out_ready;
  assign w_adv1  = !r_v1 || w_adv2;
  assign w_oxfer = r_v2 && out_ready;

  // The mode byte is a truth table indexed by {P,S,D}.
  always_comb begin
    w_rop = '0;
    for (int b = 0; b < LANES*N; b++) begin
      w_rop[b] = r_mode1[{r_p[b], r_s[b], r_d[b]}];
    end
  end

`ifdef ROP3_TRANSP_EN
  logic [N-1:0] r_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
    end else if (w_adv1 && in_valid) begin
      r_key <= key;
    end
  end

  always_comb begin
    w_res = w_rop;
    for (int k = 0; k < LANES; k++) begin
      if (r_s[k*N +: N] == r_key) begin
        w_res[k*N +: N] = r_d[k*N +: N];
      end
    end
  end
`else
  assign w_res = w_rop;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_mode1 <= '0;
      r_p     <= '0;
      r_s     <= '0;
      r_d     <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_mode1 <= in_mode;
        r_p     <= in_p;
        r_s     <= in_s;
        r_d     <= in_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_res   <= '0;
      r_mode2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_res   <= w_res;
        r_mode2 <= r_mode1;
      end
    end
  end

  // Clear wins, but a same-cycle transfer still counts as the first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= w_oxfer ? CNT_W'(1) : '0;
    end else if (w_oxfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready   = w_adv1;
  assign out_valid  = r_v2;
  assign out_result = r_res;
  assign out_mode   = r_mode2;
  assign beat_cnt   = r_cnt;

endmodule
